// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: scans latched operands MSB first, one bit per cycle,
// and produces registered one-hot great/less/equal with a done pulse.
module serial_comparator #(
    parameter int N          = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         signed_mode,
    output logic         busy,
    output logic         done,
    output logic         great,
    output logic         less,
    output logic         equal
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N-1:0]     xr, yr;
    logic             sm;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             pend_gt;

    logic accept, bit_x, bit_diff, at_msb, gt_now, last;

    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        bit_x    = xr[idx];
        bit_diff = xr[idx] ^ yr[idx];
        at_msb   = (idx == IDX_MSB);
        // A differing sign bit reverses the sense in two's complement
        gt_now   = (sm && at_msb) ? ~bit_x : bit_x;
        last     = (state == SCAN) && ((EARLY_EXIT && bit_diff) || (idx == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (accept) state_next = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = accept ? SCAN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr      <= '0;
            yr      <= '0;
            sm      <= 1'b0;
            idx     <= '0;
            found   <= 1'b0;
            pend_gt <= 1'b0;
            great   <= 1'b0;
            less    <= 1'b0;
            equal   <= 1'b0;
        end else if (accept) begin
            xr    <= x;
            yr    <= y;
            sm    <= signed_mode;
            idx   <= IDX_MSB;
            found <= 1'b0;
        end else if (state == SCAN) begin
            idx <= idx - 1'b1;
            // Without early exit the first difference is remembered until the last bit
            if (bit_diff && !found) begin
                found   <= 1'b1;
                pend_gt <= gt_now;
            end
            if (last) begin
                if (found) begin
                    great <= pend_gt;
                    less  <= ~pend_gt;
                    equal <= 1'b0;
                end else if (bit_diff) begin
                    great <= gt_now;
                    less  <= ~gt_now;
                    equal <= 1'b0;
                end else begin
                    great <= 1'b0;
                    less  <= 1'b0;
                    equal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Checks serial_comparator (early-exit and full-scan builds side by side) against an
// arithmetic reference for result and latency.
module tb_serial_comparator;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         signed_mode = 1'b0;

    logic busy_e, done_e, great_e, less_e, equal_e;
    logic busy_f, done_f, great_f, less_f, equal_f;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [2:0]  prev_res = '0;

    always #5 clk = ~clk;

    serial_comparator #(.N(N), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .signed_mode(signed_mode),
        .busy(busy_e), .done(done_e), .great(great_e), .less(less_e), .equal(equal_e)
    );

    serial_comparator #(.N(N), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .signed_mode(signed_mode),
        .busy(busy_f), .done(done_f), .great(great_f), .less(less_f), .equal(equal_f)
    );

    // {great, less, equal} from plain integer comparison
    function automatic logic [2:0] ref_rel(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
        int va, vb;
        va = int'(a);
        vb = int'(b);
        if (s) begin
            if (a[N-1]) va = va - (1 << N);
            if (b[N-1]) vb = vb - (1 << N);
        end
        return {va > vb, va < vb, va == vb};
    endfunction

    // Edges from acceptance to result for the early-exit build
    function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        d = a ^ b;
        for (int i = N - 1; i >= 0; i--)
            if (d[i]) return N - i;
        return N;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ee1"}, {busy_e, done_e, great_e, less_e, equal_e}, 5'b0);
        check({tag, " ee0"}, {busy_f, done_f, great_f, less_f, equal_f}, 5'b0);
    endtask

    // Called #1 after the acceptance edge; follows both builds up to the full-scan result
    task automatic track(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input bit keep, input string name);
        logic [2:0] res;
        int         le;
        logic [2:0] re, rf;
        res = ref_rel(a, b, s);
        le  = ref_lat(a, b);
        for (int k = 0; k <= N; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            re = (k >= le) ? res : prev_res;
            rf = (k >= N) ? res : prev_res;
            check($sformatf("%s ee1 k=%0d", name, k),
                  {busy_e, done_e, great_e, less_e, equal_e}, {k < le, k == le, re});
            check($sformatf("%s ee0 k=%0d", name, k),
                  {busy_f, done_f, great_f, less_f, equal_f}, {k < N, k == N, rf});
            if (k == 0 && !keep) start = 1'b0;
        end
        prev_res = res;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input string name);
        @(negedge clk);
        start       = 1'b1;
        x           = a;
        y           = b;
        signed_mode = s;
        @(posedge clk);
        #1;
        track(a, b, s, 1'b0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(4'b1101, 4'b1101, 1'b0, "eq_1101");
        run_op(4'b1110, 4'b1100, 1'b0, "gt_bit1");
        run_op(4'b1100, 4'b1110, 1'b0, "lt_bit1");
        run_op(4'b1011, 4'b0011, 1'b0, "msb_unsigned");
        run_op(4'b1011, 4'b0011, 1'b1, "msb_signed");

        // Operands change mid-scan with start held; start held into DONE is taken at once
        @(negedge clk);
        start       = 1'b1;
        x           = 4'b1001;
        y           = 4'b1001;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        x           = 4'b0101;
        y           = 4'b0111;
        signed_mode = 1'b1;
        track(4'b1001, 4'b1001, 1'b0, 1'b1, "held_first");
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        track(4'b0101, 4'b0111, 1'b0, 1'b0, "back_to_back");

        // Reset at E2 aborts the scan without a result
        @(negedge clk);
        start = 1'b1;
        x     = 4'b0110;
        y     = 4'b0110;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort E1 ee1", {busy_e, done_e, great_e, less_e, equal_e}, {2'b10, prev_res});
        check("abort E1 ee0", {busy_f, done_f, great_f, less_f, equal_f}, {2'b10, prev_res});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        prev_res = '0;
        check_zero("abort E2");
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_zero($sformatf("after_abort c=%0d", c));
        end
        run_op(4'b1010, 4'b1010, 1'b0, "post_reset_eq");

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < (1 << N); a++)
                for (int b = 0; b < (1 << N); b++)
                    run_op(N'(a), N'(b), 1'(s), $sformatf("exh s=%0d x=%0d y=%0d", s, a, b));

        for (int r = 0; r < 100; r++) begin
            logic [N-1:0] ra, rb;
            logic         rs;
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, $sformatf("rand%0d x=%b y=%b s=%0d", r, ra, rb, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
